// File: rtl/pattern_seq_pkg.sv
// Shared mode codes and FSM state encoding for the pattern sequencer and its helpers.
package pattern_seq_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_BIN  = 2'd0;
   localparam logic [MODE_W-1:0] MODE_GRAY = 2'd1;
   localparam logic [MODE_W-1:0] MODE_DOWN = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pattern_encode.sv
// Combinational step-to-pattern mapping; unknown mode codes fall back to binary up.
module pattern_encode
   import pattern_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic [WIDTH-1:0]  step,
   input  logic [MODE_W-1:0] mode,
   output logic [WIDTH-1:0]  code_c
);

   always_comb begin
      code_c = step;
      case (mode)
         MODE_GRAY: code_c = step ^ (step >> 1);
         MODE_DOWN: code_c = ~step;
         default:   code_c = step;
      endcase
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Clocked exhaustive stimulus sweep with per-pattern hold and truth-table capture of a 1-bit response.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned HOLD  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [MODE_W-1:0]       mode,
   input  logic                    continuous,
   input  logic                    resp,
   output logic [WIDTH-1:0]        stim,
   output logic                    stim_valid,
   output logic                    busy,
   output logic                    done,
   output logic [(1<<WIDTH)-1:0]   resp_vec
);

   localparam int unsigned NPAT   = 1 << WIDTH;
   localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [WIDTH-1:0]  STEP_LAST = WIDTH'(NPAT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

   state_t              state;
   logic [WIDTH-1:0]    step;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [MODE_W-1:0]   mode_q;
   logic [WIDTH-1:0]    enc_step_c;
   logic [MODE_W-1:0]   enc_mode_c;
   logic [WIDTH-1:0]    enc_code_c;

   // Encoder looks one step ahead so stim can be loaded as a register.
   always_comb begin
      enc_step_c = '0;
      enc_mode_c = mode_q;
      if (state == S_RUN)  enc_step_c = step + WIDTH'(1);
      if (state == S_IDLE) enc_mode_c = mode;
   end

   pattern_encode #(.WIDTH(WIDTH)) u_encode (
      .step   (enc_step_c),
      .mode   (enc_mode_c),
      .code_c (enc_code_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         step       <= '0;
         hold_cnt   <= '0;
         mode_q     <= MODE_BIN;
         stim       <= '0;
         stim_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         resp_vec   <= '0;
      end else if (stop) begin
         // Abort keeps the partially captured resp_vec.
         state      <= S_IDLE;
         stim       <= '0;
         stim_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= S_RUN;
                  mode_q     <= mode;
                  step       <= '0;
                  hold_cnt   <= '0;
                  resp_vec   <= '0;
                  stim       <= enc_code_c;
                  stim_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            S_RUN: begin
               if (hold_cnt == HOLD_LAST) begin
                  resp_vec[step] <= resp;
                  hold_cnt       <= '0;
                  if (step == STEP_LAST) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     step <= step + WIDTH'(1);
                     stim <= enc_code_c;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            S_DONE: begin
               done <= 1'b0;
               if (continuous) begin
                  state      <= S_RUN;
                  step       <= '0;
                  hold_cnt   <= '0;
                  resp_vec   <= '0;
                  stim       <= enc_code_c;
                  stim_valid <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  state      <= S_IDLE;
                  stim       <= '0;
                  stim_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed and randomized checks of pattern_sequencer against a truth-table reference model.
module tb_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         n_asrt = 0;
   int         n_fail = 0;

   // Instance A: WIDTH=2, HOLD=4
   logic       start_a = 1'b0, stop_a = 1'b0, cont_a = 1'b0;
   logic [1:0] mode_a = 2'd0;
   logic [3:0] tt_a = 4'b1000;
   logic       resp_a;
   logic [1:0] stim_a;
   logic       valid_a, busy_a, done_a;
   logic [3:0] rv_a;

   // Instance B: WIDTH=3, HOLD=1
   logic       start_b = 1'b0, stop_b = 1'b0, cont_b = 1'b0;
   logic [1:0] mode_b = 2'd0;
   logic [7:0] tt_b = 8'h00;
   logic       resp_b;
   logic [2:0] stim_b;
   logic       valid_b, busy_b, done_b;
   logic [7:0] rv_b;

   assign resp_a = tt_a[stim_a];
   assign resp_b = tt_b[stim_b];

   always #5 clk = ~clk;

   pattern_sequencer #(.WIDTH(2), .HOLD(4)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mode(mode_a),
      .continuous(cont_a), .resp(resp_a), .stim(stim_a), .stim_valid(valid_a),
      .busy(busy_a), .done(done_a), .resp_vec(rv_a)
   );

   pattern_sequencer #(.WIDTH(3), .HOLD(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mode(mode_b),
      .continuous(cont_b), .resp(resp_b), .stim(stim_b), .stim_valid(valid_b),
      .busy(busy_b), .done(done_b), .resp_vec(rv_b)
   );

   // Pattern order from the sweep rules, independent of any counter encoding.
   function automatic int pat(input int n, input int m, input int w);
      case (m)
         1:       return n ^ (n >> 1);
         2:       return ((1 << w) - 1) - n;
         default: return n;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asrt++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Full sweep(s) on instance A; continuous is held high for all but the last sweep.
   task automatic run_a(input int m, input int nsw);
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = tt_a[pat(k, m, 2)];
      mode_a  = 2'(m);
      start_a = 1'b1;
      tick();
      mode_a = 2'($urandom_range(0, 3));
      for (int s = 0; s < nsw; s++) begin
         cont_a = (s < nsw - 1);
         for (int k = 0; k < 4; k++) begin
            for (int h = 0; h < 4; h++) begin
               chk($sformatf("m%0d s%0d k%0d h%0d stim", m, s, k, h), 32'(stim_a), 32'(pat(k, m, 2)));
               chk($sformatf("m%0d s%0d k%0d h%0d valid", m, s, k, h), 32'(valid_a), 32'd1);
               chk($sformatf("m%0d s%0d k%0d h%0d busy", m, s, k, h), 32'(busy_a), 32'd1);
               chk($sformatf("m%0d s%0d k%0d h%0d done", m, s, k, h), 32'(done_a), 32'd0);
               if (k == 0 && h == 0)
                  chk($sformatf("m%0d s%0d clear", m, s), 32'(rv_a), 32'd0);
               start_a = 1'($urandom_range(0, 1));
               tick();
            end
         end
         start_a = 1'b0;
         chk($sformatf("m%0d s%0d done pulse", m, s), 32'(done_a), 32'd1);
         chk($sformatf("m%0d s%0d done busy", m, s), 32'(busy_a), 32'd0);
         chk($sformatf("m%0d s%0d done valid", m, s), 32'(valid_a), 32'd1);
         chk($sformatf("m%0d s%0d done stim", m, s), 32'(stim_a), 32'(pat(3, m, 2)));
         chk($sformatf("m%0d s%0d resp_vec", m, s), 32'(rv_a), 32'(ev));
         tick();
      end
      cont_a = 1'b0;
      chk($sformatf("m%0d idle stim", m), 32'(stim_a), 32'd0);
      chk($sformatf("m%0d idle valid", m), 32'(valid_a), 32'd0);
      chk($sformatf("m%0d idle busy", m), 32'(busy_a), 32'd0);
      chk($sformatf("m%0d idle done", m), 32'(done_a), 32'd0);
      chk($sformatf("m%0d idle resp_vec", m), 32'(rv_a), 32'(ev));
   endtask

   initial begin
      logic [3:0] ev_a;
      logic [7:0] ev_b;
      int         m;

      tick();
      tick();
      chk("reset stim", 32'(stim_a), 32'd0);
      chk("reset valid", 32'(valid_a), 32'd0);
      chk("reset busy", 32'(busy_a), 32'd0);
      chk("reset done", 32'(done_a), 32'd0);
      chk("reset resp_vec", 32'(rv_a), 32'd0);
      chk("reset resp_vec b", 32'(rv_b), 32'd0);
      rst = 1'b0;
      tick();

      // AND response across all orders; mode 3 behaves as binary up.
      tt_a = 4'b1000;
      run_a(0, 1);
      run_a(1, 1);
      run_a(2, 1);
      run_a(3, 1);

      // XOR response, three back-to-back sweeps then fall back to IDLE.
      tt_a = 4'b0110;
      run_a(0, 3);

      // Random truth tables, modes and sweep counts.
      for (int i = 0; i < 6; i++) begin
         tt_a = 4'($urandom);
         run_a(int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));
      end

      // Abort during step 2: partial capture retained.
      tt_a = 4'($urandom);
      m = int'($urandom_range(0, 3));
      mode_a  = 2'(m);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int c = 0; c < 9; c++) tick();
      chk("abort pre stim", 32'(stim_a), 32'(pat(2, m, 2)));
      stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      ev_a = {2'b00, tt_a[pat(1, m, 2)], tt_a[pat(0, m, 2)]};
      chk("abort stim", 32'(stim_a), 32'd0);
      chk("abort valid", 32'(valid_a), 32'd0);
      chk("abort busy", 32'(busy_a), 32'd0);
      chk("abort resp_vec", 32'(rv_a), 32'(ev_a));
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("abort no done c%0d", c), 32'(done_a), 32'd0);
         tick();
      end

      // Start and stop together: stop wins.
      start_a = 1'b1;
      stop_a  = 1'b1;
      tick();
      start_a = 1'b0;
      stop_a  = 1'b0;
      chk("start+stop busy", 32'(busy_a), 32'd0);
      chk("start+stop valid", 32'(valid_a), 32'd0);
      tick();
      chk("start+stop still idle", 32'(busy_a), 32'd0);

      // Reset mid-sweep after bit 0 has been captured.
      tt_a = 4'b0001 | 4'($urandom);
      mode_a  = 2'd0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      chk("pre-reset resp_vec bit0", 32'(rv_a[0]), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst stim", 32'(stim_a), 32'd0);
      chk("midrst valid", 32'(valid_a), 32'd0);
      chk("midrst busy", 32'(busy_a), 32'd0);
      chk("midrst done", 32'(done_a), 32'd0);
      chk("midrst resp_vec", 32'(rv_a), 32'd0);
      tick();
      chk("midrst no done", 32'(done_a), 32'd0);

      // WIDTH=3, HOLD=1: one pattern per cycle, done at t+9.
      for (int r = 0; r < 3; r++) begin
         tt_b = 8'($urandom);
         m = int'($urandom_range(0, 3));
         for (int k = 0; k < 8; k++) ev_b[k] = tt_b[pat(k, m, 3)];
         mode_b  = 2'(m);
         start_b = 1'b1;
         tick();
         start_b = 1'b0;
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("b r%0d k%0d stim", r, k), 32'(stim_b), 32'(pat(k, m, 3)));
            chk($sformatf("b r%0d k%0d busy", r, k), 32'(busy_b), 32'd1);
            chk($sformatf("b r%0d k%0d done", r, k), 32'(done_b), 32'd0);
            tick();
         end
         chk($sformatf("b r%0d done", r), 32'(done_b), 32'd1);
         chk($sformatf("b r%0d resp_vec", r), 32'(rv_b), 32'(ev_b));
         tick();
         chk($sformatf("b r%0d idle", r), 32'(valid_b), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Synthesizable stimulus sequencer that drives a WIDTH-bit input vector into a combinational device under test. It steps through every input combination in a selectable order and holds each pattern for HOLD clock cycles. On the final hold cycle of each pattern it captures the device's 1-bit response into a truth-table vector. It sits between bench or top-level control and the device under test, replacing hand-written delay-based stimulus with a clocked, repeatable, self-capturing sequence.

## Interface
Parameters:
- WIDTH, 2, stimulus width; legal range 1..8, which bounds resp_vec at 256 bits.
- HOLD, 10, cycles each pattern is held; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep when sampled high in IDLE; ignored otherwise.
- stop  in  1  abort; returns to IDLE on the next edge with no done pulse; has priority over start.
- mode  in  2  order: 0 binary up, 1 Gray, 2 binary down, 3 treated as 0; latched at start.
- continuous  in  1  when high at the DONE cycle, the sweep restarts immediately.
- resp  in  1  device-under-test output, sampled synchronously.
- stim  out  WIDTH  stimulus vector to the device under test.
- stim_valid  out  1  high while stim carries a sweep pattern.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a sweep completes.
- resp_vec  out  2**WIDTH  bit i = resp captured on the last hold cycle of step i.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: start=1 and stop=0.
  - Latches mode.
  - Clears resp_vec, step and hold_cnt.
- RUN:
  - stim = enc(step, mode_q).
  - hold_cnt increments 0..HOLD-1.
  - At hold_cnt==HOLD-1: resp_vec[step] <= resp, and hold_cnt <= 0.
  - If step==2**WIDTH-1, go to DONE; otherwise step+1.
- DONE: done=1 for one cycle, and stim keeps the last pattern.
  - If continuous=1: go to RUN with step=0, hold_cnt=0, resp_vec cleared.
  - Otherwise: go to IDLE.
- stop=1 in any state: IDLE next edge; resp_vec retains its partial contents.
- Encodings, with n = step:
  - binary up: n.
  - Gray: n ^ (n>>1).
  - binary down: (2**WIDTH-1) - n.
- Width rules:
  - step is WIDTH bits and never wraps inside a sweep; termination is explicit.
  - hold_cnt is max(1, $clog2(HOLD)) bits.
  - HOLD=1: resp is sampled every RUN cycle.
- Outputs in IDLE: stim=0, stim_valid=0, busy=0, done=0; resp_vec holds the last result.
- Reset values: every output is 0, including resp_vec, and the state is IDLE.
- rst mid-sweep: same as reset; no done pulse.

## Timing
- start sampled at edge t: first pattern is on stim, with stim_valid=1 and busy=1, from cycle t+1.
- Pattern k occupies cycles t+1+k*HOLD .. t+(k+1)*HOLD.
- Sweep length: 2**WIDTH*HOLD cycles.
- done is high in cycle t+1+2**WIDTH*HOLD. stim_valid=1 and busy=0 during that cycle.
- resp_vec bit for pattern k is updated at the edge ending cycle t+(k+1)*HOLD. The complete vector is visible in the DONE cycle.
- Continuous mode: the next sweep's pattern 0 appears in the cycle after DONE. There is a one-cycle DONE gap between sweeps.
- start and stop in the same cycle: stop wins and the state stays IDLE.

## Structure
- Shared package/header pattern_seq_pkg holds:
  - mode codes MODE_BIN, MODE_GRAY, MODE_DOWN;
  - state encodings S_IDLE, S_RUN, S_DONE.
- Sub-module pattern_encode: purely combinational, mapping (step, mode) -> stim. It is parametrised by WIDTH and reusable by future checkers.
- Top level holds the FSM, hold counter, step counter and resp_vec capture register.

## Test plan
All scenarios use WIDTH=2, HOLD=4, with resp = stim[1] & stim[0] unless noted.
- Binary: start pulse -> stim is 00,01,10,11 for 4 cycles each; done 17 cycles after the start edge; resp_vec=4'b1000.
- Gray: mode=1 -> stim is 00,01,11,10; resp_vec=4'b0100.
- Down: mode=2 -> stim is 11,10,01,00; resp_vec=4'b0001. Also apply mode=3 -> identical to binary.
- Continuous with resp = stim[1]^stim[0]:
  - continuous=1 for two sweeps -> done pulses 17 cycles apart; resp_vec=4'b0110 each time.
  - Drop continuous before the second DONE -> returns to IDLE.
- Abort: stop during step 2 -> IDLE next cycle, stim=0, no done; resp_vec[1:0] are captured and resp_vec[3:2]=0.
- Reset and HOLD=1:
  - rst mid-sweep -> all outputs 0 next cycle.
  - Separate HOLD=1, WIDTH=3 run -> 8 consecutive patterns; done at cycle t+9.
  - start while busy -> ignored.
